// File: rtl/uart_guess_pkg.sv
// Shared definitions for the number-guessing UART core: FSM encoding,
// character constants, message lengths and BCD helpers.
package uart_guess_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PRINT_RANGE,
    PRINT_SHORT,
    READ,
    CHECK,
    UPDATE,
    WAIT_ACK
  } state_t;

  typedef enum logic {
    BCD_INC,
    BCD_DEC
  } bcd_mode_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_QUEST = 8'h3F;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'd48;

  localparam int unsigned MSG_BAD_LEN = 3;  // "?\n\r"
  localparam int unsigned MSG_WIN_LEN = 5;  // "WIN\n\r"

  // "<lower>~<upper>\n\r"
  function automatic int unsigned range_len(input int unsigned digits);
    return 2 * digits + 3;
  endfunction

  // Digitwise BCD a < b, most significant digit decides first.
  // Operands are zero-extended to four digits by the caller.
  function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
    logic done;
    logic lt;
    done = 1'b0;
    lt   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!done && a[4*(3-i) +: 4] != b[4*(3-i) +: 4]) begin
        lt   = a[4*(3-i) +: 4] < b[4*(3-i) +: 4];
        done = 1'b1;
      end
    end
    return lt;
  endfunction

  // Character at position i of the short reply (win or reject).
  function automatic logic [7:0] short_char(input logic win, input logic [2:0] i);
    logic [7:0] ch;
    ch = CH_CR;
    if (win) begin
      case (i)
        3'd0:    ch = CH_W;
        3'd1:    ch = CH_I;
        3'd2:    ch = CH_N;
        3'd3:    ch = CH_LF;
        default: ch = CH_CR;
      endcase
    end else begin
      case (i)
        3'd0:    ch = CH_QUEST;
        3'd1:    ch = CH_LF;
        default: ch = CH_CR;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/uart_guess_core_if.sv
// Host handshake and line-buffer port of the guessing core.
// master = core side, slave = host / buffer side.
interface uart_guess_core_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 256
);
  localparam int unsigned AW = $clog2(LEN);

  logic          cmd_valid;
  logic [AW-1:0] cmd_len;
  logic          msg_valid;
  logic [AW-1:0] msg_len;
  logic          msg_ack;
  logic [AW-1:0] addr;
  logic [WIDTH-1:0] din;
  logic          we;
  logic [WIDTH-1:0] dout;

  modport master (
    input  cmd_valid, cmd_len, msg_ack, dout,
    output msg_valid, msg_len, addr, din, we
  );

  modport slave (
    output cmd_valid, cmd_len, msg_ack, dout,
    input  msg_valid, msg_len, addr, din, we
  );

endinterface

// File: rtl/uart_guess_core_bcd_step.sv
// Combinational DIGITS-wide BCD increment / decrement with ripple carry/borrow.
module bcd_step
  import uart_guess_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] d,
  input  bcd_mode_t           mode,
  output logic [4*DIGITS-1:0] q
);

  logic       carry;
  logic [3:0] nib;

  // Walk from the units digit up, propagating carry (inc) or borrow (dec).
  always_comb begin
    q     = d;
    carry = 1'b1;
    nib   = 4'h0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      nib = d[4*k +: 4];
      if (carry) begin
        if (mode == BCD_INC) begin
          if (nib == 4'h9) begin
            q[4*k +: 4] = 4'h0;
          end else begin
            q[4*k +: 4] = nib + 4'h1;
            carry       = 1'b0;
          end
        end else begin
          if (nib == 4'h0) begin
            q[4*k +: 4] = 4'h9;
          end else begin
            q[4*k +: 4] = nib - 4'h1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_guess_core.sv
// Number-guessing game engine: prints the current BCD range into the line
// buffer, reads guesses back from it, narrows the range or announces a win.
module uart_guess_core
  import uart_guess_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEN    = 256,
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] ans,
  uart_guess_core_if.master   bus
);

  localparam int unsigned AW = $clog2(LEN);
  localparam int unsigned BW = 4 * DIGITS;

  localparam logic [AW-1:0] LEN_MIN     = AW'(DIGITS);
  localparam logic [AW-1:0] LEN_MAX     = AW'(DIGITS + 2);
  localparam logic [AW-1:0] RANGE_LEN_A = AW'(range_len(DIGITS));
  localparam logic [AW-1:0] RANGE_LAST  = AW'(range_len(DIGITS) - 1);
  localparam logic [AW-1:0] WIN_LEN_A   = AW'(MSG_WIN_LEN);
  localparam logic [AW-1:0] BAD_LEN_A   = AW'(MSG_BAD_LEN);
  localparam logic [BW-1:0] ALL_NINES   = {DIGITS{4'h9}};

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [BW-1:0] lower_q, upper_q, answer_q, guess_q;
  logic [BW-1:0] guess_inc, guess_dec;
  logic [AW-1:0] len_q;
  logic [AW-1:0] msg_len_q;
  logic          bad_q;
  logic          win_q;
  logic          rd_pend_q;
  logic [AW-1:0] rd_pos_q;
  logic          read_issue;
  logic [7:0]    rd_ch;
  logic          len_ok;
  logic          guess_ok;
  logic          guess_eq;
  logic          guess_lt_ans;
  logic [AW-1:0] short_last;

  // Bound digit k (0 = most significant); leading zeros blank except units.
  function automatic logic [7:0] digit_char(input logic [BW-1:0] v, input int unsigned k);
    logic lead;
    lead = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (j <= k && v[4*(DIGITS-1-j) +: 4] != 4'h0) lead = 1'b0;
    end
    if (lead && k != DIGITS - 1) return CH_SPACE;
    return ASCII_0 + {4'h0, v[4*(DIGITS-1-k) +: 4]};
  endfunction

  // Character at position i of "<lower>~<upper>\n\r".
  function automatic logic [7:0] range_char(input logic [AW-1:0] i,
                                            input logic [BW-1:0] lo,
                                            input logic [BW-1:0] hi);
    logic [7:0] ch;
    ch = CH_CR;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (i == AW'(k))              ch = digit_char(lo, k);
      if (i == AW'(DIGITS + 1 + k)) ch = digit_char(hi, k);
    end
    if (i == AW'(DIGITS))         ch = CH_TILDE;
    if (i == AW'(2 * DIGITS + 1)) ch = CH_LF;
    return ch;
  endfunction

  bcd_step #(.DIGITS(DIGITS)) u_inc (.d(guess_q), .mode(BCD_INC), .q(guess_inc));
  bcd_step #(.DIGITS(DIGITS)) u_dec (.d(guess_q), .mode(BCD_DEC), .q(guess_dec));

  assign rd_ch        = 8'(bus.dout);
  assign len_ok       = (len_q >= LEN_MIN) && (len_q <= LEN_MAX);
  assign guess_eq     = (guess_q == answer_q);
  assign guess_lt_ans = bcd_lt(16'(guess_q), 16'(answer_q));
  assign guess_ok     = len_ok && !bad_q
                        && !bcd_lt(16'(guess_q), 16'(lower_q))
                        && !bcd_lt(16'(upper_q), 16'(guess_q));
  assign short_last   = win_q ? AW'(MSG_WIN_LEN - 1) : AW'(MSG_BAD_LEN - 1);
  assign bus.msg_len  = msg_len_q;

  // FSM state and position counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and buffer-port / handshake outputs decoded from the state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    read_issue    = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = '0;
    bus.din       = '0;
    bus.msg_valid = 1'b0;
    case (state_q)
      INIT: begin
        state_d = PRINT_RANGE;
        idx_d   = '0;
      end
      PRINT_RANGE: begin
        bus.we   = 1'b1;
        bus.addr = idx_q;
        bus.din  = WIDTH'(range_char(idx_q, lower_q, upper_q));
        if (idx_q == RANGE_LAST) begin
          state_d = WAIT_ACK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      PRINT_SHORT: begin
        bus.we   = 1'b1;
        bus.addr = idx_q;
        bus.din  = WIDTH'(short_char(win_q, 3'(idx_q)));
        if (idx_q == short_last) begin
          state_d = WAIT_ACK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      WAIT_ACK: begin
        bus.msg_valid = 1'b1;
        if (bus.msg_ack) state_d = win_q ? INIT : IDLE;
      end
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        // One extra cycle after the last address lets the final byte land.
        if (!len_ok || idx_q == len_q) begin
          state_d = CHECK;
        end else begin
          read_issue = 1'b1;
          bus.addr   = idx_q;
          idx_d      = idx_q + AW'(1);
        end
      end
      CHECK: begin
        idx_d   = '0;
        state_d = (!guess_ok || guess_eq) ? PRINT_SHORT : UPDATE;
      end
      UPDATE: begin
        state_d = PRINT_RANGE;
        idx_d   = '0;
      end
      default: state_d = INIT;
    endcase
  end

  // Game datapath: range bounds, answer, guess capture and message length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lower_q   <= '0;
      upper_q   <= ALL_NINES;
      answer_q  <= '0;
      guess_q   <= '0;
      len_q     <= '0;
      msg_len_q <= '0;
      bad_q     <= 1'b0;
      win_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_pos_q  <= '0;
    end else begin
      rd_pend_q <= read_issue;
      rd_pos_q  <= idx_q;
      if (rd_pend_q) begin
        if (rd_pos_q < LEN_MIN) begin
          if (rd_ch < ASCII_0 || rd_ch > ASCII_0 + 8'd9) bad_q <= 1'b1;
          for (int unsigned k = 0; k < DIGITS; k++) begin
            if (rd_pos_q == AW'(k)) guess_q[4*(DIGITS-1-k) +: 4] <= rd_ch[3:0];
          end
        end else if (rd_ch != CH_CR && rd_ch != CH_LF) begin
          bad_q <= 1'b1;
        end
      end
      case (state_q)
        INIT: begin
          lower_q  <= '0;
          upper_q  <= ALL_NINES;
          answer_q <= ans;
          win_q    <= 1'b0;
        end
        IDLE: begin
          if (bus.cmd_valid) begin
            len_q   <= bus.cmd_len;
            bad_q   <= 1'b0;
            guess_q <= '0;
          end
        end
        CHECK:  win_q <= guess_ok && guess_eq;
        UPDATE: begin
          if (guess_lt_ans) lower_q <= guess_inc;
          else              upper_q <= guess_dec;
        end
        PRINT_RANGE: begin
          if (idx_q == RANGE_LAST) msg_len_q <= RANGE_LEN_A;
        end
        PRINT_SHORT: begin
          if (idx_q == short_last) msg_len_q <= win_q ? WIN_LEN_A : BAD_LEN_A;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_guess_core.sv
// Directed bench: a 2-digit and a 3-digit core, each with its own line buffer.
module tb_uart_guess_core;

  localparam int unsigned LEN = 256;
  localparam int unsigned AW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [7:0]  ans_a;
  logic [11:0] ans_b;

  logic [1:0]         cv, ack, hwe;
  logic [1:0][AW-1:0] cl, hadr;
  logic [1:0][7:0]    hdin;

  logic [7:0] mem_a [LEN];
  logic [7:0] mem_b [LEN];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  uart_guess_core_if #(.WIDTH(8), .LEN(LEN)) bus_a ();
  uart_guess_core_if #(.WIDTH(8), .LEN(LEN)) bus_b ();

  uart_guess_core #(.WIDTH(8), .LEN(LEN), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst_a), .ans(ans_a), .bus(bus_a.master)
  );
  uart_guess_core #(.WIDTH(8), .LEN(LEN), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst_b), .ans(ans_b), .bus(bus_b.master)
  );

  assign bus_a.cmd_valid = cv[0];
  assign bus_a.cmd_len   = cl[0];
  assign bus_a.msg_ack   = ack[0];
  assign bus_b.cmd_valid = cv[1];
  assign bus_b.cmd_len   = cl[1];
  assign bus_b.msg_ack   = ack[1];

  wire [1:0]         mv  = {bus_b.msg_valid, bus_a.msg_valid};
  wire [1:0][AW-1:0] ml  = {bus_b.msg_len, bus_a.msg_len};
  wire [1:0]         wev = {bus_b.we, bus_a.we};
  wire [1:0][AW-1:0] adv = {bus_b.addr, bus_a.addr};
  wire [1:0][7:0]    dnv = {bus_b.din, bus_a.din};

  // Line buffers: core writes take priority over host preloads.
  always @(posedge clk) begin
    if (bus_a.we) mem_a[bus_a.addr] <= bus_a.din;
    else if (hwe[0]) mem_a[hadr[0]] <= hdin[0];
    bus_a.dout <= mem_a[bus_a.addr];
  end
  always @(posedge clk) begin
    if (bus_b.we) mem_b[bus_b.addr] <= bus_b.din;
    else if (hwe[1]) mem_b[hadr[1]] <= hdin[1];
    bus_b.dout <= mem_b[bus_b.addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_line(input int unsigned sel, input string s);
    for (int unsigned i = 0; i < s.len(); i++) begin
      hwe[sel]  = 1'b1;
      hadr[sel] = AW'(i);
      hdin[sel] = s[i];
      tick();
    end
    hwe[sel] = 1'b0;
    cv[sel]  = 1'b1;
    cl[sel]  = AW'(s.len());
    tick();
    cv[sel]  = 1'b0;
  endtask

  // Waits (bounded) for msg_valid and returns the buffer text with CR/LF escaped.
  task automatic get_msg(input int unsigned sel, input bit do_ack,
                         output string txt, output int unsigned n, output bit ok);
    logic [7:0] b;
    ok  = 1'b0;
    txt = "";
    n   = 0;
    for (int unsigned c = 0; c < 400 && !ok; c++) begin
      tick();
      if (mv[sel] === 1'b1) ok = 1'b1;
    end
    if (!ok) return;
    n = 32'(ml[sel]);
    for (int unsigned i = 0; i < n; i++) begin
      b = (sel == 0) ? mem_a[i] : mem_b[i];
      if (b == 8'h0A)      txt = {txt, "\\n"};
      else if (b == 8'h0D) txt = {txt, "\\r"};
      else                 txt = {txt, $sformatf("%c", b)};
    end
    if (do_ack) begin
      ack[sel] = 1'b1;
      tick();
      ack[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    string got; int unsigned n; bit ok;
    repeat (3) tick();
    n_checks++; if (mv[0] !== 1'b0) begin n_fail++; $display("FAIL rst_msg_valid: got %b, required 0", mv[0]); end
    n_checks++; if (ml[0] !== 8'd0) begin n_fail++; $display("FAIL rst_msg_len: got %0d, required 0", ml[0]); end
    n_checks++; if (wev[0] !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b, required 0", wev[0]); end
    n_checks++; if (adv[0] !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %0d, required 0", adv[0]); end
    n_checks++; if (dnv[0] !== 8'd0) begin n_fail++; $display("FAIL rst_din: got %0d, required 0", dnv[0]); end
    rst_a = 1'b1;
    get_msg(0, 1'b0, got, n, ok);
    n_checks++;
    if (!ok || got != " 0~99\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL first_range: got '%s' len %0d, required ' 0~99\\n\\r' len 7", got, n);
    end
    repeat (3) tick();
    n_checks++;
    if (mv[0] !== 1'b1 || wev[0] !== 1'b0 || adv[0] !== 8'd0) begin
      n_fail++; $display("FAIL hold_valid: got valid=%b we=%b addr=%0d, required 1 0 0", mv[0], wev[0], adv[0]);
    end
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    n_checks++;
    if (mv[0] !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b, required 0", mv[0]); end
  endtask

  task automatic test_update();
    string got; int unsigned n; bit ok;
    load_line(0, "50\015");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != " 0~49\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL guess_50: got '%s' len %0d, required ' 0~49\\n\\r' len 7", got, n);
    end
    load_line(0, "10");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "11~49\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL guess_10: got '%s' len %0d, required '11~49\\n\\r' len 7", got, n);
    end
  endtask

  task automatic test_invalid();
    string got; int unsigned n; bit ok;
    string bad_lines [6] = '{"4x", "5", "60", "", "12\015\012\015", "1\015"};
    foreach (bad_lines[i]) begin
      load_line(0, bad_lines[i]);
      get_msg(0, 1'b1, got, n, ok);
      n_checks++;
      if (!ok || got != "?\\n\\r" || n != 3) begin
        n_fail++; $display("FAIL reject_%0d: got '%s' len %0d, required '?\\n\\r' len 3", i, got, n);
      end
    end
    // Range must still be 11..49: 41 raises lower, 43 brings upper down to it.
    load_line(0, "41");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "42~49\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL guess_41: got '%s' len %0d, required '42~49\\n\\r' len 7", got, n);
    end
    load_line(0, "43");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "42~42\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL guess_43: got '%s' len %0d, required '42~42\\n\\r' len 7", got, n);
    end
    load_line(0, "41");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "?\\n\\r" || n != 3) begin
      n_fail++; $display("FAIL below_lower: got '%s' len %0d, required '?\\n\\r' len 3", got, n);
    end
  endtask

  task automatic test_win();
    string got; int unsigned n; bit ok;
    load_line(0, "42");
    get_msg(0, 1'b0, got, n, ok);
    n_checks++;
    if (!ok || got != "WIN\\n\\r" || n != 5) begin
      n_fail++; $display("FAIL win_42: got '%s' len %0d, required 'WIN\\n\\r' len 5", got, n);
    end
    ans_a  = 8'h07;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
  endtask

  task automatic test_ignore_cmd();
    string got; int unsigned n; bit ok; bit seen;
    repeat (3) tick();
    cv[0] = 1'b1; cl[0] = 8'd2;
    tick();
    cv[0] = 1'b0;
    get_msg(0, 1'b0, got, n, ok);
    n_checks++;
    if (!ok || got != " 0~99\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL new_game: got '%s' len %0d, required ' 0~99\\n\\r' len 7", got, n);
    end
    cv[0] = 1'b1; cl[0] = 8'd2;
    tick();
    cv[0] = 1'b0;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (mv[0] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL cmd_in_wait_ack: got msg_valid=1, required 0"); end
    load_line(0, "07");
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "WIN\\n\\r" || n != 5) begin
      n_fail++; $display("FAIL win_resampled: got '%s' len %0d, required 'WIN\\n\\r' len 5", got, n);
    end
    get_msg(0, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != " 0~99\\n\\r" || n != 7) begin
      n_fail++; $display("FAIL restart_range: got '%s' len %0d, required ' 0~99\\n\\r' len 7", got, n);
    end
  endtask

  task automatic test_digits3();
    string got; int unsigned n; bit ok;
    n_checks++;
    if (mv[1] !== 1'b0) begin n_fail++; $display("FAIL d3_rst_valid: got %b, required 0", mv[1]); end
    rst_b = 1'b1;
    get_msg(1, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "  0~999\\n\\r" || n != 9) begin
      n_fail++; $display("FAIL d3_range: got '%s' len %0d, required '  0~999\\n\\r' len 9", got, n);
    end
    load_line(1, "099");
    get_msg(1, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "100~999\\n\\r" || n != 9) begin
      n_fail++; $display("FAIL d3_carry: got '%s' len %0d, required '100~999\\n\\r' len 9", got, n);
    end
    load_line(1, "500");
    repeat (8) tick();
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (wev[1] !== 1'b0 || adv[1] !== 8'd0 || dnv[1] !== 8'd0 || mv[1] !== 1'b0) begin
      n_fail++; $display("FAIL d3_async_rst: got we=%b addr=%0d din=%0d valid=%b, required 0 0 0 0",
                         wev[1], adv[1], dnv[1], mv[1]);
    end
    repeat (2) tick();
    n_checks++;
    if (mv[1] !== 1'b0 || ml[1] !== 8'd0) begin
      n_fail++; $display("FAIL d3_rst_hold: got valid=%b len=%0d, required 0 0", mv[1], ml[1]);
    end
    rst_b = 1'b1;
    get_msg(1, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "  0~999\\n\\r" || n != 9) begin
      n_fail++; $display("FAIL d3_restart: got '%s' len %0d, required '  0~999\\n\\r' len 9", got, n);
    end
    load_line(1, "100");
    get_msg(1, 1'b1, got, n, ok);
    n_checks++;
    if (!ok || got != "WIN\\n\\r" || n != 5) begin
      n_fail++; $display("FAIL d3_win: got '%s' len %0d, required 'WIN\\n\\r' len 5", got, n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cv = '0; ack = '0; hwe = '0; cl = '0; hadr = '0; hdin = '0;
    ans_a = 8'h42;
    ans_b = 12'h100;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_update();
    test_invalid();
    test_win();
    test_ignore_cmd();
    test_digits3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_guess_core.md
UART_GUESS_CORE -- requirements
Module: uart_guess_core

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the character width of buffer data.
REQ-002 Parameter LEN, default 256, SHALL set the buffer depth; AW = clog2(LEN).
REQ-003 Parameter DIGITS, default 2, legal range 1..4, SHALL set the number of decimal digits in the game range.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  SHALL be a one-cycle pulse meaning a received line of cmd_len bytes sits in the buffer at address 0.
REQ-007 cmd_len  input  AW  SHALL be the received line length in bytes.
REQ-008 ans  input  4*DIGITS  SHALL be the BCD answer, sampled at each game (re)start.
REQ-009 msg_valid  output  1  SHALL mean that a message of msg_len bytes is ready at buffer address 0.
REQ-010 msg_len  output  AW  SHALL be the length of the ready message.
REQ-011 msg_ack  input  1  SHALL be a one-cycle pulse meaning the message was consumed.
REQ-012 addr / din / we  outputs  AW / WIDTH / 1  SHALL form the buffer port: address, write data, write enable.
REQ-013 dout  input  WIDTH  SHALL be buffer read data, valid one cycle after addr with we=0.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, PRINT_RANGE, PRINT_SHORT, READ, CHECK, UPDATE and WAIT_ACK.
REQ-015 After reset, the FSM SHALL enter INIT unprompted: lower=0, upper=all 9s, answer latched from ans; then PRINT_RANGE.
REQ-016 PRINT_RANGE SHALL write one byte per cycle, at addresses 0.., in this order: the lower digits, "~", the upper digits, "\n", "\r", for msg_len = 2*DIGITS+3.
REQ-017 Leading zero digits of a bound SHALL print as " ", except the units digit; digit characters are value+48.
REQ-018 After the last write, we SHALL drop, addr SHALL return to 0 and msg_valid SHALL rise with msg_len in the same cycle; the FSM then enters WAIT_ACK.
REQ-019 In WAIT_ACK, msg_valid SHALL stay high until msg_ack, then clear the next cycle; the FSM then enters IDLE.
REQ-020 cmd_valid SHALL be honoured only in IDLE; cmd_valid pulses in any other state SHALL be dropped with no effect.
REQ-021 On cmd_valid in IDLE, the FSM SHALL latch cmd_len and enter READ, which issues reads of addresses 0..cmd_len-1 back to back and captures each byte one cycle later.
REQ-022 A guess SHALL be valid only if it meets all of the following:
- exactly DIGITS bytes, each "0"-"9", optionally followed by any mix of "\r"/"\n";
- value within [lower, upper].
REQ-023 An invalid guess, including cmd_len=0 or cmd_len>DIGITS+2, SHALL emit "?\n\r" (msg_len 3) via PRINT_SHORT with the range unchanged.
REQ-024 A guess equal to the answer SHALL emit "WIN\n\r" (msg_len 5); after msg_ack the FSM SHALL enter INIT rather than IDLE.
REQ-025 For guess < answer, UPDATE SHALL set lower = guess+1; for guess > answer, upper = guess-1; both are BCD with ripple carry/borrow; then PRINT_RANGE.
REQ-026 Comparisons SHALL be BCD digitwise, most significant digit first; no binary conversion.
REQ-027 When lower==upper, the range SHALL still print normally; the only remaining valid guess wins.

Reset
REQ-028 Asserting rst SHALL immediately and asynchronously set all of the following: FSM=INIT, msg_valid=0, msg_len=0, addr=0, din=0, we=0, lower=0, upper=all 9s.
REQ-029 Reset mid-write or mid-WAIT_ACK SHALL abandon the message; no partial msg_valid is ever asserted.

Structure
REQ-030 Package uart_guess_pkg SHALL hold the FSM state encoding, the character constants (" ", "~", "?", "W", "I", "N", "\n", "\r", ASCII_0=48) and the message-length constants.
REQ-031 Sub-module bcd_step SHALL perform DIGITS-wide BCD increment/decrement, selected by a mode input; it is combinational and instantiated twice.

Verification
REQ-032 Reset release, DIGITS=2 -> 7 writes " 0~99\n\r", then msg_valid=1, msg_len=7, held until msg_ack.
REQ-033 ans=42, line "50\r" -> msg " 0~49\n\r"; then line "10" -> msg "11~49\n\r".
REQ-034 Line "4x", then "5" (too short), then "60" while upper=49 -> "?\n\r" each time (msg_len 3), range unchanged.
REQ-035 Line "42" -> "WIN\n\r" (msg_len 5); after msg_ack, new game message " 0~99\n\r" with ans re-sampled.
REQ-036 cmd_valid pulsed during PRINT_RANGE and during WAIT_ACK -> ignored; next output identical to the no-pulse case.
REQ-037 DIGITS=3, ans=100, guess "099" -> lower "100" printed as "100~999\n\r" (carry across all digits); rst asserted mid-print -> clean restart.
